regfile_dump: RTL and testbench

- Sequential reader for the register-file read port: on request, walks read addresses FIRST_REG..NUM_REGS-1 and streams each (index, value) pair out over a valid/ready interface.
- Sits beside the register file in the FPGA top level.
- Drives one read-address port on the register file and feeds the board display/serial debug path.
- Inspects architectural state without halting or modifying the datapath.

---
 rtl/regfile_dump.sv | 138 +++++++++++++
 tb/tb_regfile_dump.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Walks register-file read addresses FIRST_REG..NUM_REGS-1 and streams (index, value) pairs
// over valid/ready. Define REGDUMP_SKIPZERO_EN to suppress words whose captured value is zero.
module regfile_dump #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned READ_LAT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  // WAIT lasts READ_LAT cycles including the one that sees zero, so load one short.
  localparam int unsigned LoadVal = (READ_LAT > 0) ? READ_LAT - 1 : 0;
  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_REGS - 1);
  localparam logic [CntW-1:0]   CntLoad   = CntW'(LoadVal);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StPresent, StFinish} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                capture, advance;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    index_d = index_q;
    data_d  = data_q;
    busy_d  = busy_q;
    capture = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAddr;
          busy_d  = 1'b1;
          addr_d  = FirstAddr;
        end
      end
      StAddr: begin
        cnt_d = CntLoad;
        if (READ_LAT == 0) capture = 1'b1;
        else               state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) capture = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      StPresent: begin
        if (out_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
`ifdef REGDUMP_SKIPZERO_EN
      if (rd_data == '0) begin
        advance = 1'b1;
      end else begin
        data_d  = rd_data;
        index_d = addr_q;
        valid_d = 1'b1;
        state_d = StPresent;
      end
`else
      data_d  = rd_data;
      index_d = addr_q;
      valid_d = 1'b1;
      state_d = StPresent;
`endif
    end

    // Compare before incrementing so NUM_REGS == 2**ADDR_W never wraps.
    if (advance) begin
      if (addr_q == LastAddr) begin
        state_d = StFinish;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = StAddr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= FirstAddr;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      index_q <= index_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_addr   = addr_q;
  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = (state_q == StFinish);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a combinational-read and a 2-cycle registered-read instance, random
// register contents and backpressure, with a queue scoreboard checked by a separate monitor.
`timescale 1ns/1ps
module tb_regfile_dump;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned FR = 0;
`ifdef REGDUMP_SKIPZERO_EN
  localparam bit SkipZero = 1'b1;
`else
  localparam bit SkipZero = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start [2];
  logic out_ready [2];
  logic out_valid [2];
  logic busy [2];
  logic done [2];
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] out_index [2];
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] out_data [2];
  logic [DW-1:0] mem [2][NR];
  logic [DW-1:0] p1, p2;
  bit rand_ready [2];
  bit hold_ready [2];
  bit rnd [2];

  word_t q0[$];
  word_t q1[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit timed [2];
  int start_cyc [2];
  int acc_total [2];
  int done_cnt [2];
  int exp_words [2];
  int acc_base [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(FR), .READ_LAT(0)) u_dut_comb (
    .clk(clk), .reset(reset), .start(start[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_index(out_index[0]),
    .out_data(out_data[0]), .busy(busy[0]), .done(done[0])
  );

  regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(FR), .READ_LAT(2)) u_dut_reg (
    .clk(clk), .reset(reset), .start(start[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_index(out_index[1]),
    .out_data(out_data[1]), .busy(busy[1]), .done(done[1])
  );

  // Register-file models: instance 0 reads combinationally, instance 1 through two registers.
  always @(posedge clk) begin
    p1 <= mem[1][rd_addr[1]];
    p2 <= p1;
  end

  always_comb begin
    rd_data[0] = mem[0][rd_addr[0]];
    rd_data[1] = p2;
    for (int i = 0; i < 2; i++) out_ready[i] = rand_ready[i] ? rnd[i] : hold_ready[i];
  end

  initial begin
    rnd[0] = 1'b1;
    rnd[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) rnd[i] = ($urandom_range(3) != 0);
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input int inst);
    n_checks++;
    $display("FAIL %s: inst %0d got no event within budget, required one (t=%0t)", name, inst,
             $time);
  endtask

  // Monitor: compares every accepted word against the scoreboard and checks hold/done rules.
  initial begin
    bit held [2];
    word_t held_w [2];
    bit prev_done [2];
    int last_acc [2];
    word_t w;
    int qs;
    for (int i = 0; i < 2; i++) begin
      held[i] = 0;
      prev_done[i] = 0;
      last_acc[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          held[i] = 0;
          prev_done[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (held[i]) begin
            chk("hold_valid", 64'(out_valid[i]), 64'd1);
            chk("hold_word", 64'({out_index[i], out_data[i]}), 64'(held_w[i]));
          end
          held[i] = 0;
          if (out_valid[i] && out_ready[i]) begin
            qs = (i == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
              n_checks++;
              $display("FAIL unexpected_word: inst %0d got idx %0d data 0x%0h, required none", i,
                       out_index[i], out_data[i]);
            end else begin
              w = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk("word_index", 64'(out_index[i]), 64'(w.idx));
              chk("word_data", 64'(out_data[i]), 64'(w.data));
            end
            if (timed[i] && last_acc[i] > start_cyc[i])
              chk("word_spacing", 64'(cyc - last_acc[i]), 64'(lat_of(i) + 2));
            last_acc[i] = cyc;
            acc_total[i]++;
          end else if (out_valid[i]) begin
            held[i] = 1;
            held_w[i] = {out_index[i], out_data[i]};
          end
          if (done[i]) begin
            chk("done_single", 64'(prev_done[i]), 64'd0);
            qs = (i == 0) ? q0.size() : q1.size();
            chk("done_drain", 64'(qs), 64'd0);
            if (timed[i]) chk("scan_len", 64'(cyc - start_cyc[i]), 64'(NR * (lat_of(i) + 2)));
            done_cnt[i]++;
          end
          prev_done[i] = done[i];
        end
      end
    end
  end

  // Reference model: a scan emits every in-range register in order (zeros dropped if skipping).
  task automatic begin_scan(input int i, input bit time_it);
    int skipped = 0;
    word_t w;
    exp_words[i] = 0;
    for (int k = FR; k < NR; k++) begin
      if (SkipZero && mem[i][k] == '0) begin
        skipped++;
      end else begin
        w.idx = AW'(k);
        w.data = mem[i][k];
        if (i == 0) q0.push_back(w);
        else q1.push_back(w);
        exp_words[i]++;
      end
    end
    timed[i] = time_it && (skipped == 0);
    acc_base[i] = acc_total[i];
    @(posedge clk);
    #1 start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    start_cyc[i] = cyc;
    chk("busy_start", 64'(busy[i]), 64'd1);
  endtask

  task automatic wait_done(input int i, input int budget);
    bit found = 0;
    int dc = done_cnt[i];
    for (int n = 0; n < budget && !found; n++) begin
      @(posedge clk);
      #2;
      if (done[i]) found = 1;
    end
    if (!found) begin
      fail_now("done_timeout", i);
    end else begin
      @(posedge clk);
      #1;
      chk("busy_end", 64'(busy[i]), 64'd0);
      chk("done_count", 64'(done_cnt[i]), 64'(dc + 1));
      chk("word_count", 64'(acc_total[i] - acc_base[i]), 64'(exp_words[i]));
    end
    timed[i] = 0;
  endtask

  task automatic wait_word(input int i, input int idx, input int budget);
    bit found = 0;
    for (int n = 0; n < budget && !found; n++) begin
      @(posedge clk);
      #1;
      if (out_valid[i] && out_index[i] == AW'(idx)) found = 1;
    end
    if (!found) fail_now("word_timeout", i);
  endtask

  task automatic scan_rand(input int i);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NR; k++) mem[i][k] = ($urandom_range(7) == 0) ? '0 : DW'($urandom);
      rand_ready[i] = 1;
      begin_scan(i, 0);
      wait_done(i, 1000);
      rand_ready[i] = 0;
    end
  endtask

  task automatic check_reset_vals(input int i);
    chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
    chk("rst_busy", 64'(busy[i]), 64'd0);
    chk("rst_done", 64'(done[i]), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr[i]), 64'(FR));
    chk("rst_out_index", 64'(out_index[i]), 64'd0);
    chk("rst_out_data", 64'(out_data[i]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b1;
      hold_ready[i] = 1;
      rand_ready[i] = 0;
      timed[i] = 0;
      start_cyc[i] = 0;
      acc_total[i] = 0;
      done_cnt[i] = 0;
      for (int k = 0; k < NR; k++) mem[i][k] = '0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_reset_vals(i);
    start[0] = 1'b0;
    start[1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("idle_no_start", 64'(busy[i]), 64'd0);

    // Full scans with ready held high: k*3 pattern and random values.
    for (int k = 0; k < NR; k++) begin
      mem[0][k] = DW'(k * 3);
      mem[1][k] = DW'($urandom);
    end
    fork
      begin begin_scan(0, 1); wait_done(0, 200); end
      begin begin_scan(1, 1); wait_done(1, 400); end
    join

    // Backpressure on index 8 while its register keeps changing underneath.
    mem[0][8] = DW'(10);
    begin_scan(0, 0);
    wait_word(0, 8, 100);
    hold_ready[0] = 0;
    repeat (10) begin
      @(posedge clk);
      #1 mem[0][8] = DW'($urandom);
    end
    chk("bp_valid", 64'(out_valid[0]), 64'd1);
    chk("bp_index", 64'(out_index[0]), 64'd8);
    chk("bp_data", 64'(out_data[0]), 64'd10);
    mem[0][8] = DW'(10);
    hold_ready[0] = 1;
    wait_done(0, 200);

    fork
      scan_rand(0);
      scan_rand(1);
    join

    // Mid-scan start is ignored; reset mid-scan aborts and the next start begins afresh.
    for (int k = 0; k < NR; k++) mem[0][k] = DW'(k * 3 + 1);
    begin_scan(0, 0);
    wait_word(0, 5, 100);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_word(0, 12, 100);
    reset = 1'b0;
    #1;
    check_reset_vals(0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    begin_scan(0, 1);
    wait_done(0, 200);

    // Sparse pattern with a zero in the middle, then an all-zero register file.
    for (int k = 0; k < NR; k++) mem[0][k] = '0;
    begin
      int vals [16] = '{10, 20, 22, 40, 50, 60, 70, 80, 1, 2, 0, 4, 5, 6, 7, 8};
      for (int k = 0; k < 16; k++) mem[0][k + 8] = DW'(vals[k]);
    end
    begin_scan(0, 1);
    wait_done(0, 200);
    for (int k = 0; k < NR; k++) mem[1][k] = '0;
    begin_scan(1, 1);
    wait_done(1, 400);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
